// File: rtl/culsans_ace_tagger.sv
// culsans_ace_tagger: tags bypass AXI AR/AW requests with ACE snoop/domain/bar fields.
// Latency: 1 cycle on AR/AW through a 2-entry buffer; W/B/R combinational, 0 cycles.
// Backpressure: slave ar/aw ready drops only when its buffer is full (flop-decoded).
// Optional macro CULSANS_TAGGER_STATS_EN enables the shared-request counters.

package culsans_pkg;
    typedef logic [3:0]  id_t;
    typedef logic [63:0] addr_t;
    typedef logic [63:0] data_t;
    typedef logic [7:0]  strb_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        logic [2:0] snoop;
        logic [1:0] bar;
        logic [1:0] domain;
        logic       awunique;
    } aw_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [3:0] snoop;
        logic [1:0] bar;
        logic [1:0] domain;
    } ar_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [3:0] resp;
        logic       last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

// culsans_tagger_fifo: 2-entry in-order buffer for one address channel.
// Latency: 1 cycle push-to-pop; no bypass path, head entry always drives o_pop_dat.
// Backpressure: o_push_rdy low when full, even if a pop happens in the same cycle.
module culsans_tagger_fifo #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_push_vld,
    output logic o_push_rdy,
    input  T     i_push_dat,
    output logic o_pop_vld,
    input  logic i_pop_rdy,
    output T     o_pop_dat
);
    T           r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_cnt;
    logic       w_push;
    logic       w_pop;

    assign o_push_rdy = (r_cnt != 2'd2);
    assign o_pop_vld  = (r_cnt != 2'd0);
    assign o_pop_dat  = r_mem[r_rptr];
    assign w_push     = i_push_vld && o_push_rdy;
    assign w_pop      = o_pop_vld && i_pop_rdy;

    // Pointers and occupancy; simultaneous push/pop keeps count and advances both.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Payload storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= i_push_dat;
    end
endmodule

// culsans_ace_tagger: classifies AR/AW addresses (device/shared/private) and tags ACE fields.
// Latency: 1 cycle acceptance-to-master-valid per address channel; W/B/R 0 cycles.
// Backpressure: AR/AW ready from buffer occupancy only, no path from mst_resp_i.
module culsans_ace_tagger #(
    parameter logic [63:0] SharedBase   = 64'h8004_0000,
    parameter logic [63:0] SharedLength = 64'h4_0000,
    parameter logic [63:0] DeviceLimit  = 64'h8000_0000,
    parameter int unsigned CntWidth     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  culsans_pkg::req_t     slv_req_i,
    output culsans_pkg::resp_t    slv_resp_o,
    output culsans_pkg::req_t     mst_req_o,
    input  culsans_pkg::resp_t    mst_resp_i,
    output logic [CntWidth-1:0]   shared_rd_cnt_o,
    output logic [CntWidth-1:0]   shared_wr_cnt_o
);
    import culsans_pkg::*;

    // 65-bit end bound so base + length can never wrap.
    localparam logic [64:0] SharedEnd = {1'b0, SharedBase} + {1'b0, SharedLength};

    logic     w_ar_shared, w_ar_device;
    logic     w_aw_shared, w_aw_device;
    ar_chan_t w_ar_tagged, w_ar_head;
    aw_chan_t w_aw_tagged, w_aw_head;
    logic     w_ar_rdy, w_ar_vld, w_ar_push;
    logic     w_aw_rdy, w_aw_vld, w_aw_push;

    assign w_ar_shared = (slv_req_i.ar.addr >= SharedBase) &&
                         ({1'b0, slv_req_i.ar.addr} < SharedEnd);
    assign w_ar_device = (slv_req_i.ar.addr < DeviceLimit);
    assign w_aw_shared = (slv_req_i.aw.addr >= SharedBase) &&
                         ({1'b0, slv_req_i.aw.addr} < SharedEnd);
    assign w_aw_device = (slv_req_i.aw.addr < DeviceLimit);

    assign w_ar_push = slv_req_i.ar_valid && w_ar_rdy;
    assign w_aw_push = slv_req_i.aw_valid && w_aw_rdy;

    // AR tagging: ReadOnce/inner-shareable for shared, system domain for device, else NoSnoop.
    always_comb begin
        w_ar_tagged        = slv_req_i.ar;
        w_ar_tagged.snoop  = 4'b0000;
        w_ar_tagged.bar    = 2'b00;
        w_ar_tagged.domain = 2'b00;
        if (w_ar_shared)      w_ar_tagged.domain = 2'b01;
        else if (w_ar_device) w_ar_tagged.domain = 2'b11;
    end

    // AW tagging: WriteUnique/inner-shareable for shared, system domain for device, else NoSnoop.
    always_comb begin
        w_aw_tagged          = slv_req_i.aw;
        w_aw_tagged.snoop    = 3'b000;
        w_aw_tagged.bar      = 2'b00;
        w_aw_tagged.awunique = 1'b0;
        w_aw_tagged.domain   = 2'b00;
        if (w_aw_shared)      w_aw_tagged.domain = 2'b01;
        else if (w_aw_device) w_aw_tagged.domain = 2'b11;
    end

    culsans_tagger_fifo #(.T(ar_chan_t)) u_ar_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_push_vld (slv_req_i.ar_valid),
        .o_push_rdy (w_ar_rdy),
        .i_push_dat (w_ar_tagged),
        .o_pop_vld  (w_ar_vld),
        .i_pop_rdy  (mst_resp_i.ar_ready),
        .o_pop_dat  (w_ar_head)
    );

    culsans_tagger_fifo #(.T(aw_chan_t)) u_aw_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_push_vld (slv_req_i.aw_valid),
        .o_push_rdy (w_aw_rdy),
        .i_push_dat (w_aw_tagged),
        .o_pop_vld  (w_aw_vld),
        .i_pop_rdy  (mst_resp_i.aw_ready),
        .o_pop_dat  (w_aw_head)
    );

    // W/B/R pass straight through; only the address channels come from the buffers.
    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.ar       = w_ar_head;
        mst_req_o.ar_valid = w_ar_vld;
        mst_req_o.aw       = w_aw_head;
        mst_req_o.aw_valid = w_aw_vld;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.ar_ready = w_ar_rdy;
        slv_resp_o.aw_ready = w_aw_rdy;
    end

`ifdef CULSANS_TAGGER_STATS_EN
    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

    logic [CntWidth-1:0] r_rd_cnt;
    logic [CntWidth-1:0] r_wr_cnt;

    // Saturating counts of shared-region requests accepted from the core.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_ar_push && w_ar_shared && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + CntOne;
            if (w_aw_push && w_aw_shared && (r_wr_cnt != '1)) r_wr_cnt <= r_wr_cnt + CntOne;
        end
    end

    assign shared_rd_cnt_o = r_rd_cnt;
    assign shared_wr_cnt_o = r_wr_cnt;
`else
    assign shared_rd_cnt_o = '0;
    assign shared_wr_cnt_o = '0;
`endif
endmodule
